// File: rtl/calc_core_seq.sv
// rtl/calc_core_seq.sv - multi-cycle BCD calculator core: digit edit, convert, add/sub/mul/div, binary-to-BCD
module calc_core_seq #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     inc_a,
    input  logic [DIGITS-1:0]     inc_b,
    input  logic [1:0]            op,
    input  logic                  start,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   a_bcd,
    output logic [4*DIGITS-1:0]   b_bcd,
    output logic [8*DIGITS-1:0]   result_bcd,
    output logic                  neg,
    output logic                  err_div0,
    output logic                  busy,
    output logic                  done,
    output logic                  show_result
);
    localparam int OPW = 4 * DIGITS;
    localparam int RW  = 2 * OPW;
    localparam int CW  = $clog2(RW + 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_EXEC, S_B2B, S_DONE} state_t;

    state_t          state_q;
    logic [1:0]      op_q;
    logic [OPW-1:0]  a_q, b_q;
    logic [RW-1:0]   acc_a_q;     // operand A, then multiplicand (shifts left) or dividend/quotient
    logic [OPW-1:0]  acc_b_q;     // operand B, then multiplier (shifts right) or divisor
    logic [OPW-1:0]  rem_q;
    logic [RW-1:0]   res_q;       // binary result, consumed MSB-first by double-dabble
    logic [RW-1:0]   bcd_q;
    logic            neg_work_q, err_work_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   result_q;
    logic            neg_q, err_q, busy_q, done_q, show_q;

    logic [OPW-1:0]  a_d, b_d;
    logic [3:0]      dig_a, dig_b;
    logic [RW-1:0]   conv_a_d;
    logic [OPW-1:0]  conv_b_d;
    logic [RW-1:0]   sum_d, diff_d, mul_res_d;
    logic            a_lt_b;
    logic [OPW:0]    div_sh, div_sub;
    logic            div_ge;
    logic [OPW-1:0]  rem_d, quot_d;
    logic [RW-1:0]   dd_adj, dd_bcd_d, dd_bin_d;

    function automatic logic [OPW-1:0] step_digits(input logic [OPW-1:0] v, input logic [DIGITS-1:0] p);
        logic [OPW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (p[i]) r[i*4 +: 4] = (v[i*4 +: 4] >= 4'd9) ? 4'd0 : v[i*4 +: 4] + 4'd1;
        end
        return r;
    endfunction

    // Datapath next values: digit edits, BCD-to-binary step, arithmetic steps, double-dabble step
    always_comb begin
        a_d   = step_digits(a_q, inc_a);
        b_d   = step_digits(b_q, inc_b);
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(DIGITS - 1 - i)) begin
                dig_a = a_q[i*4 +: 4];
                dig_b = b_q[i*4 +: 4];
            end
        end
        conv_a_d  = acc_a_q * RW'(10) + RW'(dig_a);
        conv_b_d  = acc_b_q * OPW'(10) + OPW'(dig_b);
        sum_d     = acc_a_q + RW'(acc_b_q);
        a_lt_b    = acc_a_q < RW'(acc_b_q);
        diff_d    = a_lt_b ? (RW'(acc_b_q) - acc_a_q) : (acc_a_q - RW'(acc_b_q));
        mul_res_d = acc_b_q[0] ? (res_q + acc_a_q) : res_q;
        div_sh    = {rem_q, acc_a_q[OPW-1]};
        div_sub   = div_sh - {1'b0, acc_b_q};
        div_ge    = div_sh >= {1'b0, acc_b_q};
        rem_d     = div_ge ? div_sub[OPW-1:0] : div_sh[OPW-1:0];
        quot_d    = {acc_a_q[OPW-2:0], div_ge};
        dd_adj    = bcd_q;
        for (int j = 0; j < RW / 4; j++) begin
            if (bcd_q[j*4 +: 4] >= 4'd5) dd_adj[j*4 +: 4] = bcd_q[j*4 +: 4] + 4'd3;
        end
        dd_bcd_d  = {dd_adj[RW-2:0], res_q[RW-1]};
        dd_bin_d  = {res_q[RW-2:0], 1'b0};
    end

    // Control FSM with registered outputs; clear aborts from any state without a done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;  op_q <= OP_ADD;
            a_q <= '0;  b_q <= '0;  acc_a_q <= '0;  acc_b_q <= '0;  rem_q <= '0;
            res_q <= '0;  bcd_q <= '0;  neg_work_q <= 1'b0;  err_work_q <= 1'b0;  cnt_q <= '0;
            result_q <= '0;  neg_q <= 1'b0;  err_q <= 1'b0;
            busy_q <= 1'b0;  done_q <= 1'b0;  show_q <= 1'b0;
        end else if (clear) begin
            state_q <= S_IDLE;
            a_q <= '0;  b_q <= '0;
            result_q <= '0;  neg_q <= 1'b0;  err_q <= 1'b0;
            busy_q <= 1'b0;  done_q <= 1'b0;  show_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        busy_q  <= 1'b1;
                        acc_a_q <= '0;  acc_b_q <= '0;  rem_q <= '0;  res_q <= '0;
                        neg_work_q <= 1'b0;  err_work_q <= 1'b0;  cnt_q <= '0;
                        state_q <= S_CONV;
                    end else if (|{inc_a, inc_b}) begin
                        a_q    <= a_d;
                        b_q    <= b_d;
                        show_q <= 1'b0;
                    end
                end
                S_CONV: begin
                    acc_a_q <= conv_a_d;
                    acc_b_q <= conv_b_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DIGITS - 1)) begin
                        cnt_q <= '0;
                        // A zero divisor is known from the BCD digits, so the divide is never started
                        if (op_q == OP_DIV && b_q == '0) begin
                            bcd_q      <= '0;
                            err_work_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    cnt_q <= cnt_q + CW'(1);
                    bcd_q <= '0;
                    case (op_q)
                        OP_ADD: begin
                            res_q <= sum_d;  cnt_q <= '0;  state_q <= S_B2B;
                        end
                        OP_SUB: begin
                            res_q <= diff_d;  neg_work_q <= a_lt_b;  cnt_q <= '0;  state_q <= S_B2B;
                        end
                        OP_MUL: begin
                            res_q   <= mul_res_d;
                            acc_a_q <= {acc_a_q[RW-2:0], 1'b0};
                            acc_b_q <= {1'b0, acc_b_q[OPW-1:1]};
                        end
                        default: begin
                            rem_q   <= rem_d;
                            acc_a_q <= RW'(quot_d);
                            res_q   <= RW'(quot_d);
                        end
                    endcase
                    if ((op_q == OP_MUL || op_q == OP_DIV) && cnt_q == CW'(OPW - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_B2B;
                    end
                end
                S_B2B: begin
                    bcd_q <= dd_bcd_d;
                    res_q <= dd_bin_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(RW - 1)) state_q <= S_DONE;
                end
                S_DONE: begin
                    result_q <= bcd_q;
                    neg_q    <= neg_work_q;
                    err_q    <= err_work_q;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    show_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_bcd       = a_q;
    assign b_bcd       = b_q;
    assign result_bcd  = result_q;
    assign neg         = neg_q;
    assign err_div0    = err_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign show_result = show_q;

endmodule

// File: tb/tb_calc_core_seq.sv
// tb/tb_calc_core_seq.sv - directed self-checking bench for calc_core_seq
module tb_calc_core_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  inc_a, inc_b, op;
    logic        start, clear;
    logic [7:0]  a_bcd, b_bcd;
    logic [15:0] result_bcd;
    logic        neg, err_div0, busy, done, show_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_core_seq #(.DIGITS(2)) dut (
        .clk(clk), .rst(rst_n), .inc_a(inc_a), .inc_b(inc_b), .op(op),
        .start(start), .clear(clear), .a_bcd(a_bcd), .b_bcd(b_bcd),
        .result_bcd(result_bcd), .neg(neg), .err_div0(err_div0), .busy(busy),
        .done(done), .show_result(show_result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse(input logic [1:0] ma, input logic [1:0] mb, input int n);
        for (int i = 0; i < n; i++) begin
            inc_a = ma;
            inc_b = mb;
            tick();
            inc_a = '0;
            inc_b = '0;
        end
    endtask

    task automatic set_ops(input int a, input int b);
        pulse(2'b10, 2'b00, a / 10);
        pulse(2'b01, 2'b00, a % 10);
        pulse(2'b00, 2'b10, b / 10);
        pulse(2'b00, 2'b01, b % 10);
    endtask

    task automatic count_done(input string tag, input int cycles, input int exp);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) n++;
        end
        check(tag, n, exp);
    endtask

    task automatic run(input logic [1:0] o, input logic [1:0] ia, input int lat, input bit disturb, input string tag);
        int k;
        bit seen;
        op    = o;
        start = 1'b1;
        inc_a = ia;
        tick();
        start = 1'b0;
        inc_a = '0;
        check({tag, " busy_after_start"}, busy, 1);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 40) begin
            if (disturb && k == 4) begin
                start = 1'b1;
                inc_b = 2'b01;
            end
            tick();
            k++;
            start = 1'b0;
            inc_b = '0;
            if (done) seen = 1'b1;
        end
        check({tag, " latency"}, k, lat);
        tick();
        check({tag, " busy_after_done"}, busy, 0);
        check({tag, " done_one_cycle"}, done, 0);
        if (disturb) count_done({tag, " extra_done"}, 30, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        inc_a = '0;
        inc_b = '0;
        op    = '0;
        start = 1'b0;
        clear = 1'b0;
        repeat (3) tick();
        check("reset a_bcd", a_bcd, 0);
        check("reset b_bcd", b_bcd, 0);
        check("reset result", result_bcd, 0);
        check("reset neg", neg, 0);
        check("reset err", err_div0, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset show", show_result, 0);
        rst_n = 1'b1;
        tick();

        set_ops(47, 85);
        check("edit a", a_bcd, 32'h47);
        check("edit b", b_bcd, 32'h85);
        run(2'b00, 2'b00, 20, 1'b0, "add");
        check("add result", result_bcd, 32'h0132);
        check("add neg", neg, 0);
        check("add show", show_result, 1);

        do_clear();
        set_ops(12, 57);
        run(2'b01, 2'b00, 20, 1'b0, "sub_neg");
        check("sub_neg result", result_bcd, 32'h0045);
        check("sub_neg neg", neg, 1);
        do_clear();
        set_ops(57, 12);
        run(2'b01, 2'b00, 20, 1'b0, "sub_pos");
        check("sub_pos result", result_bcd, 32'h0045);
        check("sub_pos neg", neg, 0);

        do_clear();
        set_ops(99, 99);
        run(2'b10, 2'b00, 27, 1'b0, "mul_max");
        check("mul_max result", result_bcd, 32'h9801);
        do_clear();
        set_ops(0, 37);
        run(2'b10, 2'b00, 27, 1'b0, "mul_zero");
        check("mul_zero result", result_bcd, 32'h0000);

        do_clear();
        set_ops(85, 0);
        run(2'b11, 2'b00, 3, 1'b0, "div0");
        check("div0 err", err_div0, 1);
        check("div0 result", result_bcd, 0);
        check("div0 neg", neg, 0);
        pulse(2'b00, 2'b01, 7);
        run(2'b11, 2'b00, 27, 1'b0, "div");
        check("div result", result_bcd, 32'h0012);
        check("div err", err_div0, 0);

        pulse(2'b01, 2'b00, 1);
        check("edit_after_done show", show_result, 0);
        check("edit_after_done result", result_bcd, 32'h0012);
        check("edit_after_done a", a_bcd, 32'h86);

        run(2'b00, 2'b01, 20, 1'b0, "start_with_inc");
        check("start_with_inc a", a_bcd, 32'h86);
        check("start_with_inc result", result_bcd, 32'h0093);

        run(2'b00, 2'b00, 20, 1'b1, "busy_ignore");
        check("busy_ignore b", b_bcd, 32'h07);
        check("busy_ignore result", result_bcd, 32'h0093);

        op    = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear a", a_bcd, 0);
        check("clear b", b_bcd, 0);
        check("clear result", result_bcd, 0);
        check("clear neg", neg, 0);
        check("clear busy", busy, 0);
        check("clear show", show_result, 0);
        count_done("clear no_done", 40, 0);

        pulse(2'b00, 2'b10, 9);
        check("wrap b 9", b_bcd, 32'h90);
        pulse(2'b00, 2'b10, 1);
        check("wrap b 10", b_bcd, 32'h00);

        set_ops(85, 7);
        op    = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid a", a_bcd, 0);
        check("rst_mid b", b_bcd, 0);
        check("rst_mid result", result_bcd, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        count_done("rst_mid no_done", 40, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
